io_uart_responder: RTL

//  IO-space responder on the core's memory-stage IO bus.
//  - Decodes IO_memAddr/IO_memWr/IO_memWData and returns IO_memRData the same cycle.
//  - Drives an LED register.
//  - Feeds writes to a UART transmit FIFO, drained by an 8N1 serializer FSM.

---
 rtl/io_uart_responder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/io_uart_responder.sv
// io_uart_responder
//   IO-space responder for the core's memory-stage IO bus. It holds the LED
//   register and a UART transmit path. The transmit path is a byte FIFO
//   drained by an 8N1 serializer.
// Ports
//   clk_i          core clock, rising edge
//   reset_i        synchronous active-high reset
//   IO_memAddr_i   byte address; [22] selects IO space, [4:2] the register
//   IO_memWData_i  store data; only [7:0] is meaningful
//   IO_memWr_i     one-cycle store strobe
//   IO_memRData_o  combinational load data for the current address
//   leds_o         LED register
//   uart_tx_o      registered serial TX line, idle high
// Register map (index = addr[4:2])
//   0 LEDS   RW [7:0]
//   1 TXDATA W  [7:0] pushed into the TX FIFO; reads 0
//   2 STATUS R  {count[15:8], overflow[3], empty[2], full[1], busy[0]};
//            W  a 1 in bit 3 clears overflow
//   3-7      reads 0, writes ignored
module io_uart_responder #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] IO_memAddr_i,
  input  logic [31:0] IO_memWData_i,
  input  logic        IO_memWr_i,
  output logic [31:0] IO_memRData_o,
  output logic [7:0]  leds_o,
  output logic        uart_tx_o
);

  localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD;
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] REG_LEDS   = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Address bits outside [22] and [4:2], and the upper store data, are don't-care.
  logic unused_bits;
  assign unused_bits = ^{IO_memAddr_i[31:23], IO_memAddr_i[21:5],
                         IO_memAddr_i[1:0], IO_memWData_i[31:8]};

  logic              io_sel;
  logic [2:0]        reg_idx;
  logic              wr_en;
  logic              wr_leds;
  logic              wr_txdata;
  logic              wr_status;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              push_drop;
  logic              pop;
  logic              overflow;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_idx;
  logic              busy;
  logic [31:0]       status_word;

  // Write decode; the strobe is only honoured inside IO space.
  assign io_sel    = IO_memAddr_i[22];
  assign reg_idx   = IO_memAddr_i[4:2];
  assign wr_en     = IO_memWr_i & io_sel;
  assign wr_leds   = wr_en & (reg_idx == REG_LEDS);
  assign wr_txdata = wr_en & (reg_idx == REG_TXDATA);
  assign wr_status = wr_en & (reg_idx == REG_STATUS);

  // FIFO flags come from the pre-edge count, so a full FIFO drops a push even if it also pops.
  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign push_ok    = wr_txdata & ~fifo_full;
  assign push_drop  = wr_txdata & fifo_full;

  // The serializer takes a byte from IDLE, or at the last cycle of STOP for gapless frames.
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

  assign busy        = ~fifo_empty | (state != ST_IDLE);
  assign status_word = {16'd0, 8'(fifo_count), 4'd0, overflow, fifo_empty, fifo_full, busy};

  // Combinational load data: no wait states.
  always_comb begin
    IO_memRData_o = '0;
    if (io_sel) begin
      case (reg_idx)
        REG_LEDS:   IO_memRData_o = {24'd0, leds_o};
        REG_STATUS: IO_memRData_o = status_word;
        default:    IO_memRData_o = '0;
      endcase
    end
  end

  // LED register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      leds_o <= '0;
    end else if (wr_leds) begin
      leds_o <= IO_memWData_i[7:0];
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= IO_memWData_i[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (wr_status && IO_memWData_i[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // 8N1 serializer. The line register follows the pre-edge state. This gives
  // the write-to-start-bit latency of two cycles and keeps each bit DIV cycles wide.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            bit_idx   <= '0;
            baud_cnt  <= BAUD_LOAD;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            baud_cnt  <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              bit_idx   <= '0;
              baud_cnt  <= BAUD_LOAD;
              state     <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      case (state)
        ST_START: uart_tx_o <= 1'b0;
        ST_DATA:  uart_tx_o <= shift_reg[0];
        default:  uart_tx_o <= 1'b1;
      endcase
    end
  end

endmodule
